// File: rtl/md_scheduler.sv
// Multiply/divide issue scheduler: latches operands, pulses the multdiv unit, and arbitrates the RegFile write port.
// Optional build macro MD_TIMEOUT_EN adds a 6-bit WAIT timeout that writes 6 to r30.
module md_scheduler (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_div,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  output logic        md_mult,
  output logic        md_div,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_rdy,
  input  logic        w_we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, START, WAIT, WRITE} state_t;

  state_t      state, state_nxt;
  logic [31:0] op_a_p0, op_b_p0;
  logic        op_div_p0;
  logic [4:0]  op_rd_p0;
  logic [31:0] res_data_p1;
  logic [4:0]  res_dst_p1;
  logic        cap_en;
  logic [31:0] cap_data;
  logic [4:0]  cap_dst;

`ifdef MD_TIMEOUT_EN
  logic [5:0]  tmo_cnt;
`endif

  // Exceptions replace the quotient/product with a cause code bound for r30.
  function automatic logic [31:0] capture_value(input logic exc, input logic div,
                                                input logic [31:0] res);
    if (!exc)     return res;
    else if (div) return 32'd5;
    else          return 32'd4;
  endfunction

  function automatic logic [4:0] capture_dst(input logic exc, input logic [4:0] rd);
    return exc ? 5'd30 : rd;
  endfunction

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    cap_data  = 32'd0;
    cap_dst   = 5'd0;
    case (state)
      IDLE:  if (issue_valid) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT: begin
        if (md_rdy) begin
          state_nxt = WRITE;
          cap_en    = 1'b1;
          cap_data  = capture_value(md_exception, op_div_p0, md_result);
          cap_dst   = capture_dst(md_exception, op_rd_p0);
        end
`ifdef MD_TIMEOUT_EN
        // Counter reads 62 in the last WAIT cycle, so WRITE lands 63 cycles after entry.
        else if (tmo_cnt == 6'd62) begin
          state_nxt = WRITE;
          cap_en    = 1'b1;
          cap_data  = 32'd6;
          cap_dst   = 5'd30;
        end
`endif
      end
      WRITE: if (!w_we) state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand latch; stage p1: captured result and destination
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_a_p0     <= 32'd0;
      op_b_p0     <= 32'd0;
      op_div_p0   <= 1'b0;
      op_rd_p0    <= 5'd0;
      res_data_p1 <= 32'd0;
      res_dst_p1  <= 5'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && issue_valid) begin
        op_a_p0   <= issue_a;
        op_b_p0   <= issue_b;
        op_div_p0 <= issue_div;
        op_rd_p0  <= issue_rd;
      end
      if (cap_en) begin
        res_data_p1 <= cap_data;
        res_dst_p1  <= cap_dst;
      end
    end
  end

`ifdef MD_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               tmo_cnt <= 6'd0;
    else if (state == START) tmo_cnt <= 6'd0;
    else if (state == WAIT)  tmo_cnt <= tmo_cnt + 6'd1;
  end
`endif

  assign issue_ready = (state == IDLE);
  assign md_mult     = (state == START) && !op_div_p0;
  assign md_div      = (state == START) && op_div_p0;
  assign md_opA      = op_a_p0;
  assign md_opB      = op_b_p0;
  assign stall       = (state != IDLE) || issue_valid;

  // Writeback stage owns the port whenever it writes; r0 results are dropped.
  assign ctrl_writeEnable = w_we | ((state == WRITE) && (res_dst_p1 != 5'd0));
  assign ctrl_writeReg    = w_we ? w_addr : res_dst_p1;
  assign data_writeReg    = w_we ? w_data : res_data_p1;

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: expected start pulses and RegFile writes are queued by stimulus
// and checked by an independent monitor on the falling edge.
module tb_md_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_div;
  logic [31:0] issue_a, issue_b;
  logic [4:0]  issue_rd;
  logic        issue_ready, md_mult, md_div;
  logic [31:0] md_opA, md_opB, md_result;
  logic        md_exception, md_rdy, w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        stall;

  int vectors = 0;
  int miscompares = 0;

  logic        pulse_q[$];
  logic [36:0] wr_q[$];

  md_scheduler dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_div(issue_div),
    .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .md_mult(md_mult), .md_div(md_div),
    .md_opA(md_opA), .md_opB(md_opB),
    .md_result(md_result), .md_exception(md_exception), .md_rdy(md_rdy),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .stall(stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every start pulse and RegFile write must match the head of its queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (md_mult || md_div) begin
        vectors++;
        if (md_mult && md_div) begin
          miscompares++;
          $display("FAIL pulse_both: md_mult=1 md_div=1, expected exactly one");
        end else if (pulse_q.size() == 0) begin
          miscompares++;
          $display("FAIL pulse_unexpected: md_div=%0d, expected no pulse", md_div);
        end else begin
          logic exp_div;
          exp_div = pulse_q.pop_front();
          if (md_div !== exp_div) begin
            miscompares++;
            $display("FAIL pulse_kind: md_div=%0d, expected %0d", md_div, exp_div);
          end
        end
      end
      if (ctrl_writeEnable) begin
        vectors++;
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL write_unexpected: r%0d=%0d, expected no write", ctrl_writeReg, data_writeReg);
        end else begin
          logic [36:0] exp_wr;
          exp_wr = wr_q.pop_front();
          if ({ctrl_writeReg, data_writeReg} !== exp_wr) begin
            miscompares++;
            $display("FAIL write_data: r%0d=%0d, expected r%0d=%0d",
                     ctrl_writeReg, data_writeReg, exp_wr[36:32], exp_wr[31:0]);
          end
        end
      end
    end
  end

  // Returns one ns after the edge that moves the scheduler into START.
  task automatic issue(input logic div, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(posedge clock); #1;
    issue_valid = 1'b1; issue_div = div; issue_a = a; issue_b = b; issue_rd = rd;
    @(negedge clock);
    check("stall_on_issue", stall, 1);
    check("ready_on_issue", issue_ready, 1);
    @(posedge clock); #1;
    issue_valid = 1'b0;
  endtask

  task automatic rdy_pulse(input logic [31:0] res, input logic exc);
    @(posedge clock); #1;
    md_rdy = 1'b1; md_result = res; md_exception = exc;
    @(posedge clock); #1;
    md_rdy = 1'b0; md_exception = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; issue_valid = 1'b0; issue_div = 1'b0; issue_a = '0; issue_b = '0; issue_rd = '0;
    md_result = '0; md_exception = 1'b0; md_rdy = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    #2 reset = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_ready", issue_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_mult", md_mult, 0);
    check("rst_we", ctrl_writeEnable, 0);
    check("rst_opA", md_opA, 0);
    issue_valid = 1'b1;
    #1 check("rst_stall_issue", stall, 1);
    issue_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b0;

    // Mult 7*6 -> r3=42, rdy after 32 cycles
    pulse_q.push_back(1'b0);
    wr_q.push_back({5'd3, 32'd42});
    issue(1'b0, 32'd7, 32'd6, 5'd3);
    @(negedge clock);
    check("mult_stall_start", stall, 1);
    check("mult_opA", md_opA, 7);
    check("mult_opB", md_opB, 6);
    repeat (30) @(posedge clock);
    rdy_pulse(32'd42, 1'b0);
    @(negedge clock);
    check("mult_we", ctrl_writeEnable, 1);
    check("mult_stall_write", stall, 1);
    @(negedge clock);
    check("mult_stall_after", stall, 0);
    check("mult_ready_after", issue_ready, 1);

    // Div by zero -> r30=5; issue_valid in WAIT must be ignored
    pulse_q.push_back(1'b1);
    wr_q.push_back({5'd30, 32'd5});
    issue(1'b1, 32'd9, 32'd0, 5'd4);
    @(posedge clock); #1;
    issue_valid = 1'b1; issue_a = 32'd99; issue_rd = 5'd7;
    repeat (2) @(posedge clock); #1;
    check("div_ignore_issue", md_opA, 9);
    check("div_ready_busy", issue_ready, 0);
    issue_valid = 1'b0;
    rdy_pulse(32'd123, 1'b1);
    @(negedge clock);
    check("div_we", ctrl_writeEnable, 1);
    @(posedge clock); #1;

    // Port conflict: w_we for two cycles starting with md_rdy
    pulse_q.push_back(1'b0);
    wr_q.push_back({5'd8, 32'h11});
    wr_q.push_back({5'd8, 32'h22});
    wr_q.push_back({5'd9, 32'd15});
    issue(1'b0, 32'd3, 32'd5, 5'd9);
    @(posedge clock); #1;
    md_rdy = 1'b1; md_result = 32'd15; w_we = 1'b1; w_addr = 5'd8; w_data = 32'h11;
    @(posedge clock); #1;
    md_rdy = 1'b0; md_result = 32'd0; w_data = 32'h22;
    @(negedge clock);
    check("conf_stall_held", stall, 1);
    @(posedge clock); #1;
    w_we = 1'b0;
    @(negedge clock);
    check("conf_md_write", ctrl_writeReg, 9);
    @(negedge clock);
    check("conf_idle", issue_ready, 1);

    // rd=0: no write, IDLE the next cycle
    pulse_q.push_back(1'b0);
    issue(1'b0, 32'd2, 32'd2, 5'd0);
    rdy_pulse(32'd4, 1'b0);
    @(negedge clock);
    check("rd0_no_we", ctrl_writeEnable, 0);
    @(negedge clock);
    check("rd0_ready", issue_ready, 1);
    check("rd0_stall", stall, 0);

    // Reset in WAIT abandons the op; later md_rdy ignored
    pulse_q.push_back(1'b0);
    issue(1'b0, 32'd1, 32'd1, 5'd5);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("rstw_ready", issue_ready, 1);
    check("rstw_opA", md_opA, 0);
    @(posedge clock); #1 reset = 1'b0;
    rdy_pulse(32'd77, 1'b0);
    @(negedge clock);
    check("rstw_no_we", ctrl_writeEnable, 0);
    check("rstw_ready2", issue_ready, 1);

`ifdef MD_TIMEOUT_EN
    // Timeout: r30=6 written 63 cycles after entering WAIT
    pulse_q.push_back(1'b0);
    wr_q.push_back({5'd30, 32'd6});
    issue(1'b0, 32'd1, 32'd2, 5'd6);
    @(posedge clock);
    repeat (62) @(posedge clock);
    @(negedge clock);
    check("tmo_not_yet", ctrl_writeEnable, 0);
    @(negedge clock);
    check("tmo_we", ctrl_writeEnable, 1);
    @(negedge clock);
`endif

    repeat (2) @(negedge clock);
    check("pulse_q_drained", pulse_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 SHALL have port clock  input  1  master clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port issue_valid  input  1  execute stage presents a mult/div instruction.
REQ-004 SHALL have port issue_div  input  1  1 = div, 0 = mult.
REQ-005 SHALL have ports issue_a, issue_b  input  32 each  bypassed operands.
REQ-006 SHALL have port issue_rd  input  5  destination register.
REQ-007 SHALL have port issue_ready  output  1  high only in IDLE.
REQ-008 SHALL have ports md_mult, md_div  output  1 each  start pulses to the multdiv unit.
REQ-009 SHALL have ports md_opA, md_opB  output  32 each  registered operands to the multdiv unit.
REQ-010 SHALL have ports md_result  input  32, md_exception  input  1, md_rdy  input  1  from the multdiv unit.
REQ-011 SHALL have ports w_we  input  1, w_addr  input  5, w_data  input  32  writeback-stage request.
REQ-012 SHALL have ports ctrl_writeEnable  output  1, ctrl_writeReg  output  5, data_writeReg  output  32  to the RegFile.
REQ-013 SHALL have port stall  output  1  freezes PC, FD and DX.

Function
REQ-014 SHALL implement four states: IDLE, START, WAIT, WRITE.
REQ-015 SHALL, in IDLE with issue_valid=1, latch issue_a/b/div/rd on the edge and enter START.
REQ-016 SHALL, in START, assert exactly one of md_mult or md_div for one cycle, then enter WAIT.
REQ-017 SHALL, in WAIT with md_rdy=1, capture the result and enter WRITE.
REQ-018 SHALL select the captured value as md_result when md_exception=0, 4 for mult with exception, and 5 for div with exception.
REQ-019 SHALL set the captured destination to register 30 on exception, else to the latched rd.
REQ-020 SHALL give the writeback stage priority on the RegFile port: ctrl_* equal w_* whenever w_we=1.
REQ-021 SHALL, in WRITE with w_we=0, drive ctrl_writeEnable=1 with the captured destination and data for one cycle, then return to IDLE.
REQ-022 SHALL remain in WRITE while w_we=1, holding the captured result.
REQ-023 SHALL suppress the write when the captured destination is 0, returning from WRITE to IDLE on the first w_we=0 cycle.
REQ-024 SHALL drive stall = (state != IDLE) OR (issue_valid AND state == IDLE).
REQ-025 SHALL drop stall in the cycle after the WRITE-state write.
REQ-026 SHALL ignore issue_valid outside IDLE.
REQ-027 SHALL ignore md_rdy outside WAIT.
REQ-028 SHALL drive md_opA/md_opB from the latched registers at all times.

Reset
REQ-029 SHALL on reset go to IDLE and clear all latched operands, result, destination and the timeout counter.
REQ-030 SHALL hold md_mult=md_div=0 and ctrl_writeEnable=0 during reset; stall=0 unless issue_valid=1.
REQ-031 SHALL on reset mid-operation abandon the operation with no RegFile write.

Configuration
REQ-032 SHALL, with macro MD_TIMEOUT_EN defined, run a 6-bit counter cleared on entering WAIT and incremented each WAIT cycle.
REQ-033 SHALL, with MD_TIMEOUT_EN defined and the counter reaching 63 without md_rdy, capture value 6 for register 30 and enter WRITE.
REQ-034 SHALL, without MD_TIMEOUT_EN, wait in WAIT indefinitely and omit the counter.

Verification
REQ-035 SHALL cover mult: a=7, b=6, rd=3; md_rdy after 32 cycles with result 42 -> single md_mult pulse in START; r3=42 written; stall high from the issue cycle through the write cycle.
REQ-036 SHALL cover div by zero: a=9, b=0, rd=4; md_rdy with md_exception=1 -> r30=5 written; r4 untouched.
REQ-037 SHALL cover port conflict: md_rdy arrives while w_we=1 for 2 cycles (w_addr=8) -> r8 written first; md result written on the third cycle; result unchanged.
REQ-038 SHALL cover rd=0 with mult exception=0 -> no RegFile write; return to IDLE; issue_ready=1 the next cycle.
REQ-039 SHALL cover reset asserted in WAIT -> IDLE immediately; no write; a later md_rdy pulse is ignored.
REQ-040 SHALL cover, with MD_TIMEOUT_EN defined, md_rdy never asserted -> r30=6 written 63 cycles after entering WAIT.
